palette_arbiter: RTL and testbench

PALETTE_ARBITER -- requirements
Module: palette_arbiter

---
 rtl/palette_arbiter_pkg.sv | 35 +++
 rtl/palette_slot_fsm.sv | 60 ++++++
 rtl/palette_arbiter.sv | 157 +++++++++++++++
 tb/tb_palette_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : palette_arbiter_pkg
// Purpose  : Shared phase constants, widths and slot-state encoding for the
//            palette RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package palette_arbiter_pkg;

    localparam int PAL_DW = 16;
    localparam int PAL_IW = 12;
    localparam int PAL_AW = PAL_IW + 1;

    localparam logic [1:0] PH_VADDR = 2'd0;
    localparam logic [1:0] PH_VCAP  = 2'd1;
    localparam logic [1:0] PH_CADDR = 2'd2;
    localparam logic [1:0] PH_CCAP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VID_RD = 2'd1,
        ST_CPU_RD = 2'd2,
        ST_CPU_WR = 2'd3
    } slot_state_t;

    function automatic logic is_slot_start(input logic [1:0] ph);
        return (ph == PH_VADDR) || (ph == PH_CADDR);
    endfunction

    function automatic slot_state_t cpu_state(input logic wr);
        return wr ? ST_CPU_WR : ST_CPU_RD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_slot_fsm.sv
`default_nettype none
// ============================================================================
// Module   : palette_slot_fsm
// Purpose  : Pixel phase counter and slot ownership state for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module palette_slot_fsm
    import palette_arbiter_pkg::*;
#(
    parameter bit BLANK_CPU_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_blank_n,
    input  logic        i_cpu_pend,
    input  logic        i_cpu_wr,
    output logic [1:0]  o_ph,
    output slot_state_t o_state,
    output slot_state_t o_state_nxt
);

    logic [1:0]  r_ph_q;
    logic [1:0]  w_ph_d;
    slot_state_t r_state_q;
    slot_state_t w_state_d;

    // Ownership is decided only at the two slot-start phases and held through
    // the matching capture phase.
    always_comb begin
        w_ph_d    = r_ph_q + 2'd1;
        w_state_d = r_state_q;
        if (r_ph_q == PH_VADDR) begin
            if (i_blank_n) begin
                w_state_d = ST_VID_RD;
            end else if (BLANK_CPU_EN && i_cpu_pend) begin
                w_state_d = cpu_state(i_cpu_wr);
            end else begin
                w_state_d = ST_IDLE;
            end
        end else if (r_ph_q == PH_CADDR) begin
            w_state_d = i_cpu_pend ? cpu_state(i_cpu_wr) : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ph_q    <= PH_VADDR;
            r_state_q <= ST_IDLE;
        end else begin
            r_ph_q    <= w_ph_d;
            r_state_q <= w_state_d;
        end
    end

    assign o_ph        = r_ph_q;
    assign o_state     = r_state_q;
    assign o_state_nxt = w_state_d;

endmodule
`default_nettype wire

// File: rtl/palette_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : palette_arbiter
// Purpose  : Time-slices one palette RAM between the pixel pipeline and CPU.
// Revision : 1.0 - initial release
// ============================================================================
module palette_arbiter
    import palette_arbiter_pkg::*;
#(
    parameter bit BLANK_CPU_EN = 1'b1
) (
    input  logic              CLK_24M,
    input  logic              nRESET,
    input  logic              nBNKB,
    input  logic [PAL_IW-1:0] VID_ADDR,
    input  logic              CPU_REQ,
    input  logic              CPU_WR,
    input  logic [PAL_IW-1:0] CPU_ADDR,
    input  logic [PAL_DW-1:0] CPU_WDATA,
    input  logic [1:0]        BANK_SET,
    input  logic [1:0]        SHD_SET,
    output logic [PAL_AW-1:0] PAL_ADDR,
    output logic [PAL_DW-1:0] PAL_DOUT,
    input  logic [PAL_DW-1:0] PAL_DIN,
    output logic              nPAL_WE,
    output logic              nPAL_OE,
    output logic [PAL_DW-1:0] CPU_RDATA,
    output logic              CPU_ACK,
    output logic [PAL_DW-1:0] PC,
    output logic              SHADOW,
    output logic              CLK_6MB_EN
);

    logic [1:0]        w_ph;
    slot_state_t       w_state;
    slot_state_t       w_state_nxt;
    logic              w_cpu_pend;

    logic              r_bank_pend_q, w_bank_pend_d;
    logic              r_bank_q,      w_bank_d;
    logic              r_shadow_q,    w_shadow_d;
    logic [PAL_AW-1:0] r_addr_q,      w_addr_d;
    logic [PAL_DW-1:0] r_dout_q,      w_dout_d;
    logic              r_we_n_q,      w_we_n_d;
    logic              r_oe_n_q,      w_oe_n_d;
    logic [PAL_DW-1:0] r_rdata_q,     w_rdata_d;
    logic              r_ack_q,       w_ack_d;
    logic [PAL_DW-1:0] r_pc_q,        w_pc_d;

    // The CPU still sees REQ high while ACK is visible; that request is done.
    assign w_cpu_pend = CPU_REQ && !r_ack_q;

    palette_slot_fsm #(
        .BLANK_CPU_EN (BLANK_CPU_EN)
    ) u_slot_fsm (
        .clk         (CLK_24M),
        .rst_n       (nRESET),
        .i_blank_n   (nBNKB),
        .i_cpu_pend  (w_cpu_pend),
        .i_cpu_wr    (CPU_WR),
        .o_ph        (w_ph),
        .o_state     (w_state),
        .o_state_nxt (w_state_nxt)
    );

    always_comb begin
        w_bank_pend_d = r_bank_pend_q;
        if (BANK_SET[1]) begin
            w_bank_pend_d = 1'b1;
        end else if (BANK_SET[0]) begin
            w_bank_pend_d = 1'b0;
        end
        // Bank is committed once per pixel so both slots of a pixel agree.
        w_bank_d = (w_ph == PH_VADDR) ? w_bank_pend_d : r_bank_q;

        w_shadow_d = r_shadow_q;
        if (SHD_SET[1]) begin
            w_shadow_d = 1'b1;
        end else if (SHD_SET[0]) begin
            w_shadow_d = 1'b0;
        end

        w_addr_d  = r_addr_q;
        w_dout_d  = r_dout_q;
        w_we_n_d  = 1'b1;
        w_oe_n_d  = 1'b1;
        w_rdata_d = r_rdata_q;
        w_ack_d   = 1'b0;
        w_pc_d    = r_pc_q;

        if (is_slot_start(w_ph)) begin
            case (w_state_nxt)
                ST_VID_RD: begin
                    w_addr_d = {w_bank_d, VID_ADDR};
                    w_oe_n_d = 1'b0;
                end
                ST_CPU_RD: begin
                    w_addr_d = {w_bank_d, CPU_ADDR};
                    w_oe_n_d = 1'b0;
                end
                ST_CPU_WR: begin
                    w_addr_d = {w_bank_d, CPU_ADDR};
                    w_dout_d = CPU_WDATA;
                    w_we_n_d = 1'b0;
                end
                default: begin
                end
            endcase
        end else begin
            w_ack_d = (w_state == ST_CPU_RD) || (w_state == ST_CPU_WR);
            if (w_state == ST_CPU_RD) begin
                w_rdata_d = PAL_DIN;
            end
            if (w_ph == PH_VCAP) begin
                w_pc_d = (w_state == ST_VID_RD) ? PAL_DIN : '0;
            end
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (!nRESET) begin
            r_bank_pend_q <= 1'b0;
            r_bank_q      <= 1'b0;
            r_shadow_q    <= 1'b0;
            r_addr_q      <= '0;
            r_dout_q      <= '0;
            r_we_n_q      <= 1'b1;
            r_oe_n_q      <= 1'b1;
            r_rdata_q     <= '0;
            r_ack_q       <= 1'b0;
            r_pc_q        <= '0;
        end else begin
            r_bank_pend_q <= w_bank_pend_d;
            r_bank_q      <= w_bank_d;
            r_shadow_q    <= w_shadow_d;
            r_addr_q      <= w_addr_d;
            r_dout_q      <= w_dout_d;
            r_we_n_q      <= w_we_n_d;
            r_oe_n_q      <= w_oe_n_d;
            r_rdata_q     <= w_rdata_d;
            r_ack_q       <= w_ack_d;
            r_pc_q        <= w_pc_d;
        end
    end

    assign PAL_ADDR   = r_addr_q;
    assign PAL_DOUT   = r_dout_q;
    assign nPAL_WE    = r_we_n_q;
    assign nPAL_OE    = r_oe_n_q;
    assign CPU_RDATA  = r_rdata_q;
    assign CPU_ACK    = r_ack_q;
    assign PC         = r_pc_q;
    assign SHADOW     = r_shadow_q;
    assign CLK_6MB_EN = (w_ph == PH_CCAP);

endmodule
`default_nettype wire

// File: tb/tb_palette_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_palette_arbiter
// Purpose  : Self-checking bench for palette_arbiter (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_palette_arbiter;

    logic        CLK_24M = 1'b0;
    logic        nRESET;
    logic        nBNKB;
    logic [11:0] VID_ADDR;
    logic        CPU_REQ;
    logic        CPU_WR;
    logic [11:0] CPU_ADDR;
    logic [15:0] CPU_WDATA;
    logic [1:0]  BANK_SET;
    logic [1:0]  SHD_SET;
    logic [12:0] PAL_ADDR;
    logic [15:0] PAL_DOUT;
    logic [15:0] PAL_DIN;
    logic        nPAL_WE;
    logic        nPAL_OE;
    logic [15:0] CPU_RDATA;
    logic        CPU_ACK;
    logic [15:0] PC;
    logic        SHADOW;
    logic        CLK_6MB_EN;

    int checks = 0;
    int errors = 0;
    int bph    = 0;

    typedef struct {
        logic        wr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        nbnkb;
        logic [11:0] vaddr;
        logic [1:0]  bset;
        logic [12:0] eaddr;
        logic [15:0] epc;
    } vec_t;

    exp_t        exp_q[$];
    logic [15:0] pc_q[$];

    always #5 CLK_24M = ~CLK_24M;

    function automatic logic [15:0] ram_data(input logic [12:0] a);
        return {a, 3'b000} ^ 16'h5A5A;
    endfunction

    assign PAL_DIN = ram_data(PAL_ADDR);

    palette_arbiter #(
        .BLANK_CPU_EN (1'b1)
    ) dut (
        .CLK_24M    (CLK_24M),
        .nRESET     (nRESET),
        .nBNKB      (nBNKB),
        .VID_ADDR   (VID_ADDR),
        .CPU_REQ    (CPU_REQ),
        .CPU_WR     (CPU_WR),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WDATA  (CPU_WDATA),
        .BANK_SET   (BANK_SET),
        .SHD_SET    (SHD_SET),
        .PAL_ADDR   (PAL_ADDR),
        .PAL_DOUT   (PAL_DOUT),
        .PAL_DIN    (PAL_DIN),
        .nPAL_WE    (nPAL_WE),
        .nPAL_OE    (nPAL_OE),
        .CPU_RDATA  (CPU_RDATA),
        .CPU_ACK    (CPU_ACK),
        .PC         (PC),
        .SHADOW     (SHADOW),
        .CLK_6MB_EN (CLK_6MB_EN)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_24M);
        #1;
        bph = (bph + 1) % 4;
    endtask

    task automatic align(input int p);
        for (int k = 0; k < 4 && bph != p; k++) tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"},    PC,        32'h0);
        check({tag, "_rdata"}, CPU_RDATA, 32'h0);
        check({tag, "_ack"},   CPU_ACK,   32'h0);
        check({tag, "_shadow"},SHADOW,    32'h0);
        check({tag, "_we_n"},  nPAL_WE,   32'h1);
        check({tag, "_oe_n"},  nPAL_OE,   32'h1);
        check({tag, "_addr"},  PAL_ADDR,  32'h0);
        check({tag, "_dout"},  PAL_DOUT,  32'h0);
    endtask

    task automatic cpu_op(input logic wr, input logic [11:0] a, input logic [15:0] wd,
                          input logic bank, output int lat, output int we_cnt, output int we_ph);
        exp_t e;
        e.wr   = wr;
        e.data = ram_data({bank, a});
        exp_q.push_back(e);
        CPU_REQ = 1'b1; CPU_WR = wr; CPU_ADDR = a; CPU_WDATA = wd;
        lat = 0; we_cnt = 0; we_ph = -1;
        for (int k = 0; k < 12; k++) begin
            tick();
            lat++;
            if (!nPAL_WE) begin
                we_cnt++;
                we_ph = (bph + 3) % 4;
                check("wr_addr", PAL_ADDR, {bank, a});
                check("wr_data", PAL_DOUT, wd);
            end
            if (CPU_ACK) break;
        end
        if (!CPU_ACK) begin
            checks++;
            errors++;
            $display("FAIL cpu_ack_timeout: no ACK within %0d cycles, required ACK", lat);
        end
        CPU_REQ = 1'b0;
    endtask

    // Strobe exclusivity, ACK spacing and the CPU scoreboard consumer.
    logic prev_ack = 1'b0;
    always @(negedge CLK_24M) begin : mon
        exp_t e;
        check("strobe_overlap", {31'h0, (!nPAL_WE && !nPAL_OE)}, 32'h0);
        if (CPU_ACK) begin
            check("ack_consecutive", {31'h0, prev_ack}, 32'h0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: ACK=1 with no outstanding access, required none");
            end else begin
                e = exp_q.pop_front();
                if (!e.wr) check("cpu_rdata", CPU_RDATA, e.data);
            end
        end
        prev_ack = CPU_ACK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   lat, wec, wep, acks;

        nRESET = 1'b0; nBNKB = 1'b1; VID_ADDR = 12'h0; CPU_REQ = 1'b0; CPU_WR = 1'b0;
        CPU_ADDR = 12'h0; CPU_WDATA = 16'h0; BANK_SET = 2'b00; SHD_SET = 2'b00;

        vecs[0] = '{1'b1, 12'h123, 2'b00, 13'h0123, ram_data(13'h0123)};
        vecs[1] = '{1'b1, 12'h123, 2'b10, 13'h0123, ram_data(13'h0123)};
        vecs[2] = '{1'b1, 12'h123, 2'b00, 13'h1123, ram_data(13'h1123)};
        vecs[3] = '{1'b1, 12'hABC, 2'b01, 13'h1ABC, ram_data(13'h1ABC)};
        vecs[4] = '{1'b1, 12'hABC, 2'b00, 13'h0ABC, ram_data(13'h0ABC)};
        vecs[5] = '{1'b0, 12'h456, 2'b00, 13'h0000, 16'h0000};
        vecs[6] = '{1'b1, 12'hFFF, 2'b11, 13'h0FFF, ram_data(13'h0FFF)};
        vecs[7] = '{1'b1, 12'h000, 2'b00, 13'h1000, ram_data(13'h1000)};
        vecs[8] = '{1'b1, 12'h800, 2'b00, 13'h1800, ram_data(13'h1800)};

        repeat (3) tick();
        check_reset("reset");
        VID_ADDR = 12'h123;
        nRESET   = 1'b1;
        bph      = 0;
        tick();
        check("first_ph0_addr", PAL_ADDR, 32'h0123);
        check("first_ph0_oe_n", nPAL_OE,  32'h0);

        for (int i = 0; i < 9; i++) begin
            align(0);
            nBNKB    = vecs[i].nbnkb;
            VID_ADDR = vecs[i].vaddr;
            pc_q.push_back(vecs[i].epc);
            tick();
            if (vecs[i].nbnkb) begin
                check($sformatf("vec%0d_addr", i), PAL_ADDR, vecs[i].eaddr);
                check($sformatf("vec%0d_oe_n", i), nPAL_OE, 32'h0);
            end else begin
                check($sformatf("vec%0d_blank_oe_n", i), nPAL_OE, 32'h1);
            end
            check($sformatf("vec%0d_we_n", i), nPAL_WE, 32'h1);
            BANK_SET = vecs[i].bset;
            tick();
            BANK_SET = 2'b00;
            check($sformatf("vec%0d_pc", i), PC, pc_q.pop_front());
            tick();
            check($sformatf("vec%0d_pix_en_ph3", i), CLK_6MB_EN, 32'h1);
            tick();
            check($sformatf("vec%0d_pix_en_ph0", i), CLK_6MB_EN, 32'h0);
        end
        nBNKB = 1'b1;

        SHD_SET = 2'b10;
        check("shadow_before_edge", SHADOW, 32'h0);
        tick(); SHD_SET = 2'b00;
        check("shadow_on", SHADOW, 32'h1);
        SHD_SET = 2'b01; tick(); SHD_SET = 2'b00;
        check("shadow_off", SHADOW, 32'h0);
        SHD_SET = 2'b11; tick(); SHD_SET = 2'b00;
        check("shadow_both_on", SHADOW, 32'h1);

        // CPU write during active display, request raised ahead of PH0.
        BANK_SET = 2'b01; tick(); BANK_SET = 2'b00;
        VID_ADDR = 12'h123;
        align(0);
        repeat (4) tick();
        cpu_op(1'b1, 12'h010, 16'h7FFF, 1'b0, lat, wec, wep);
        check("wr_we_cycles", wec, 32'd1);
        check("wr_we_phase", wep, 32'd2);
        check("wr_ack_latency", lat, 32'd4);
        check("wr_video_pc", PC, ram_data(13'h0123));
        tick();
        check("ack_single_cycle", CPU_ACK, 32'h0);

        // Active-display read raised in PH3: worst-case wait.
        align(3);
        cpu_op(1'b0, 12'h2A0, 16'h0, 1'b0, lat, wec, wep);
        check("rd_latency_from_ph3", lat - 1, 32'd4);

        // Blanked read raised in PH3 uses the video slot.
        align(3);
        nBNKB = 1'b0;
        cpu_op(1'b0, 12'h3C3, 16'h0, 1'b0, lat, wec, wep);
        check("blank_rd_latency_le4", {31'h0, (lat - 1) <= 4}, 32'h1);
        check("blank_pc_zero", PC, 32'h0);
        nBNKB = 1'b1;

        // Bank switch mid-pixel must not affect the current CPU slot.
        VID_ADDR = 12'h123;
        align(1);
        begin
            exp_t e;
            e.wr = 1'b0; e.data = ram_data(13'h0055);
            exp_q.push_back(e);
        end
        BANK_SET = 2'b10; CPU_REQ = 1'b1; CPU_WR = 1'b0; CPU_ADDR = 12'h055;
        tick(); BANK_SET = 2'b00;
        check("bank_hold_ph1", PAL_ADDR, 32'h0123);
        tick();
        check("bank_not_early_cpu", PAL_ADDR, 32'h0055);
        tick();
        check("bank_rd_ack", CPU_ACK, 32'h1);
        CPU_REQ = 1'b0;
        tick();
        check("bank_next_ph0", PAL_ADDR, 32'h1123);

        // Held requests: one ACK per pixel, active and blanked.
        align(0);
        CPU_REQ = 1'b1; CPU_WR = 1'b0; CPU_ADDR = 12'h077;
        for (int k = 0; k < 8; k++) exp_q.push_back('{1'b0, ram_data(13'h1077)});
        acks = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (CPU_ACK) acks++;
        end
        CPU_REQ = 1'b0;
        check("held_active_acks", acks, 32'd8);
        repeat (4) tick();
        nBNKB = 1'b0; CPU_REQ = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, ram_data(13'h1077)});
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (CPU_ACK) acks++;
        end
        CPU_REQ = 1'b0; nBNKB = 1'b1;
        check("held_blank_acks", acks, 32'd4);

        // Reset asserted while a write strobe is active.
        align(0);
        CPU_REQ = 1'b1; CPU_WR = 1'b1; CPU_ADDR = 12'h0AA; CPU_WDATA = 16'h1234;
        repeat (3) tick();
        check("rstwr_we_low", nPAL_WE, 32'h0);
        nRESET = 1'b0;
        tick();
        CPU_REQ = 1'b0;
        check_reset("rstwr");
        repeat (2) tick();
        check_reset("rstwr_hold");
        VID_ADDR = 12'h321;
        nRESET   = 1'b1;
        bph      = 0;
        tick();
        check("rel_ph0_addr", PAL_ADDR, 32'h0321);
        check("rel_ph0_oe_n", nPAL_OE, 32'h0);
        tick();
        check("rel_pc", PC, ram_data(13'h0321));

        repeat (4) tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
